// File: rtl/idelay_bank.sv
// Multi-channel tap-programmable input delay line: per-channel tap counter plus a
// history shift register; dataout is idatain delayed by tap+2 clock cycles.
module idelay_bank #(
    parameter int    CHANNELS     = 4,
    parameter int    TAP_W        = 5,
    parameter string IDELAY_TYPE  = "FIXED",
    parameter int    IDELAY_VALUE = 0,
    parameter string PIPE_SEL     = "FALSE"
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       ce,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS-1:0]       ldpipeen,
    input  logic [CHANNELS*TAP_W-1:0] cntvaluein,
    input  logic [CHANNELS-1:0]       idatain,
    output logic [CHANNELS-1:0]       dataout,
    output logic [CHANNELS*TAP_W-1:0] cntvalueout
);

    localparam int               DEPTH       = 1 << TAP_W;
    localparam bit               IS_FIXED    = (IDELAY_TYPE == "FIXED");
    localparam bit               IS_VAR_LOAD = (IDELAY_TYPE == "VAR_LOAD");
    localparam bit               USE_PIPE    = (PIPE_SEL == "TRUE");
    localparam logic [TAP_W-1:0] INIT_TAP    = TAP_W'(IDELAY_VALUE);

    generate
        if (!(IDELAY_TYPE == "FIXED" || IDELAY_TYPE == "VARIABLE" || IDELAY_TYPE == "VAR_LOAD")) begin : g_bad_type
            $fatal(1, "idelay_bank: illegal IDELAY_TYPE");
        end
        if (IDELAY_VALUE < 0 || IDELAY_VALUE >= DEPTH) begin : g_bad_value
            $fatal(1, "idelay_bank: IDELAY_VALUE out of tap range");
        end
        if (!(PIPE_SEL == "TRUE" || PIPE_SEL == "FALSE")) begin : g_bad_pipe
            $fatal(1, "idelay_bank: illegal PIPE_SEL");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [TAP_W-1:0] tap_reg;
            logic [TAP_W-1:0] tap_next;
            logic [TAP_W-1:0] pipe_reg;
            logic [TAP_W-1:0] load_val;
            logic [TAP_W-1:0] cnt_in;
            logic [DEPTH-1:0] hist_reg;
            logic             dout_reg;

            assign cnt_in = cntvaluein[gi*TAP_W +: TAP_W];

            // Load takes priority over stepping; FIXED never moves off the initial tap.
            always_comb begin
                load_val = INIT_TAP;
                tap_next = tap_reg;
                if (IS_VAR_LOAD) begin
                    load_val = USE_PIPE ? pipe_reg : cnt_in;
                end
                if (!IS_FIXED) begin
                    if (ld[gi]) begin
                        tap_next = load_val;
                    end else if (ce[gi]) begin
                        tap_next = inc[gi] ? tap_reg + TAP_W'(1) : tap_reg - TAP_W'(1);
                    end
                end
            end

            // dataout samples the history with the pre-update tap, so a new tap
            // applies from the following sample onward.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tap_reg  <= INIT_TAP;
                    pipe_reg <= '0;
                    hist_reg <= '0;
                    dout_reg <= 1'b0;
                end else begin
                    tap_reg <= tap_next;
                    if (!IS_FIXED && ldpipeen[gi]) begin
                        pipe_reg <= cnt_in;
                    end
                    hist_reg <= {hist_reg[DEPTH-2:0], idatain[gi]};
                    dout_reg <= hist_reg[tap_reg];
                end
            end

            assign dataout[gi]                     = dout_reg;
            assign cntvalueout[gi*TAP_W +: TAP_W] = tap_reg;
        end
    endgenerate

endmodule

// File: tb/tb_idelay_bank.sv
// Directed bench for idelay_bank: four instances (FIXED, VARIABLE, VAR_LOAD, VAR_LOAD+pipe)
// share one stimulus bus; each test checks only the instance it targets.
module tb_idelay_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ce, inc, ld, ldpipeen, idatain;
    logic [19:0] cntvaluein;
    logic [3:0]  dout_fix, dout_var, dout_vl, dout_vp;
    logic [19:0] cnt_fix, cnt_var, cnt_vl, cnt_vp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    idelay_bank #(.CHANNELS(4), .TAP_W(5), .IDELAY_TYPE("FIXED"), .IDELAY_VALUE(3), .PIPE_SEL("FALSE")) u_fix (
        .clk(clk), .rst(rst), .ce(ce), .inc(inc), .ld(ld), .ldpipeen(ldpipeen),
        .cntvaluein(cntvaluein), .idatain(idatain), .dataout(dout_fix), .cntvalueout(cnt_fix));
    idelay_bank #(.CHANNELS(4), .TAP_W(5), .IDELAY_TYPE("VARIABLE"), .IDELAY_VALUE(31), .PIPE_SEL("FALSE")) u_var (
        .clk(clk), .rst(rst), .ce(ce), .inc(inc), .ld(ld), .ldpipeen(ldpipeen),
        .cntvaluein(cntvaluein), .idatain(idatain), .dataout(dout_var), .cntvalueout(cnt_var));
    idelay_bank #(.CHANNELS(4), .TAP_W(5), .IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(5), .PIPE_SEL("FALSE")) u_vl (
        .clk(clk), .rst(rst), .ce(ce), .inc(inc), .ld(ld), .ldpipeen(ldpipeen),
        .cntvaluein(cntvaluein), .idatain(idatain), .dataout(dout_vl), .cntvalueout(cnt_vl));
    idelay_bank #(.CHANNELS(4), .TAP_W(5), .IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(0), .PIPE_SEL("TRUE")) u_vp (
        .clk(clk), .rst(rst), .ce(ce), .inc(inc), .ld(ld), .ldpipeen(ldpipeen),
        .cntvaluein(cntvaluein), .idatain(idatain), .dataout(dout_vp), .cntvalueout(cnt_vp));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] rep(input logic [4:0] t);
        return {t, t, t, t};
    endfunction

    logic [3:0] q[$];
    int         taps[4];
    logic [3:0] exp_v;
    logic [3:0] past;

    initial begin
        rst = 1'b1; ce = '0; inc = '0; ld = '0; ldpipeen = '0; idatain = '0; cntvaluein = '0;
        tick(); tick();
        check("rst_cnt_fix", cnt_fix, rep(5'd3));
        check("rst_cnt_var", cnt_var, rep(5'd31));
        check("rst_cnt_vl",  cnt_vl,  rep(5'd5));
        check("rst_cnt_vp",  cnt_vp,  rep(5'd0));
        check("rst_dout",    {dout_fix, dout_var, dout_vl, dout_vp}, 32'h0);
        rst = 1'b0;
        tick();

        // 1: FIXED tap 3 -> pulse appears tap+2 = 5 edges after it is driven
        idatain = 4'b0001;
        for (int e = 1; e <= 7; e++) begin
            ce  = {4{e[0]}};
            ld  = ~ce;
            inc = {4{e[1]}};
            tick();
            idatain = '0;
            $display("t1 edge=%0d dout_fix0=%0b", e, dout_fix[0]);
            check("t1_pulse", dout_fix[0], (e == 5) ? 1 : 0);
        end
        check("t1_cnt_fix", cnt_fix, rep(5'd3));
        ce = '0; ld = '0;

        // 2: VARIABLE wrap up and down around 31/0
        ld = 4'hF; tick(); ld = '0;
        check("t2_load31", cnt_var, rep(5'd31));
        ce = 4'hF; inc = 4'hF; tick();
        check("t2_wrap_up", cnt_var, rep(5'd0));
        inc = 4'h0; tick();
        check("t2_wrap_dn", cnt_var, rep(5'd31));
        ce = '0;
        check("t2_fix_still", cnt_fix, rep(5'd3));

        // 3: VAR_LOAD direct, ld beats ce, other channels untouched
        cntvaluein = {5'd13, 5'd12, 5'd11, 5'd10};
        ld = 4'hF; tick(); ld = '0;
        check("t3_init", cnt_vl, {5'd13, 5'd12, 5'd11, 5'd10});
        cntvaluein[9:5] = 5'd17;
        ld = 4'b0010; ce = 4'b0010; inc = 4'hF; tick();
        ld = '0; ce = '0;
        check("t3_ld_ce", cnt_vl, {5'd13, 5'd12, 5'd17, 5'd10});

        // 4: VAR_LOAD through pipeline register; same-cycle ld uses old register
        cntvaluein = rep(5'd9); ldpipeen = 4'hF; tick(); ldpipeen = '0;
        ld = 4'hF; tick();
        check("t4_pipe9", cnt_vp, rep(5'd9));
        cntvaluein = rep(5'd4); ldpipeen = 4'hF; tick();
        check("t4_old_reg", cnt_vp, rep(5'd9));
        ldpipeen = '0; tick();
        check("t4_new_reg", cnt_vp, rep(5'd4));
        ld = '0;

        // 5: random data against reference queue, taps 0/7/19/31
        taps = '{0, 7, 19, 31};
        cntvaluein = {5'd31, 5'd19, 5'd7, 5'd0};
        ld = 4'hF; tick(); ld = '0;
        check("t5_taps", cnt_vl, {5'd31, 5'd19, 5'd7, 5'd0});
        for (int cyc = 0; cyc < 80; cyc++) begin
            idatain = 4'($urandom);
            q.push_front(idatain);
            tick();
            if (cyc >= 33) begin
                for (int n = 0; n < 4; n++) begin
                    past = q[taps[n] + 1];
                    exp_v[n] = past[n];
                end
                $display("t5 cyc=%0d dout=%b exp=%b", cyc, dout_vl, exp_v);
                check("t5_data", dout_vl, exp_v);
            end
        end

        // 6: async reset mid-stream at tap 12, then IDELAY_VALUE+2 = 7 edges to first valid bit
        cntvaluein = rep(5'd12);
        ld = 4'hF; tick(); ld = '0;
        idatain = 4'hF;
        repeat (16) tick();
        check("t6_pre_dout", dout_vl, 4'hF);
        check("t6_pre_cnt", cnt_vl, rep(5'd12));
        #3 rst = 1'b1;
        #1;
        check("t6_async_dout", dout_vl, 4'h0);
        check("t6_async_cnt", cnt_vl, rep(5'd5));
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            $display("t6 edge=%0d dout=%b", e, dout_vl);
            check("t6_release", dout_vl, (e >= 7) ? 4'hF : 4'h0);
        end
        check("t6_cnt_after", cnt_vl, rep(5'd5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
